gelato_split_table_pool: RTL and testbench
==========================================

// Module: gelato_split_table_pool
// PURPOSE
//  Parametrised successor to the single-table select/update split table: a shared pool of
//  NUM_ENTRIES SIMT split entries (pc, active mask, warp id), each with its own state.
//  Adds launch-time allocation, divergence splits into a free entry, writeback retire, and
//  round-robin PC selection toward fetch. Sits between warp scheduler/branch unit and fetch.
// PARAMETERS
//  NUM_ENTRIES  16  pool depth, power of two >= 2
//  NUM_WARPS    8   warp count; warp id width WID_W = $clog2(NUM_WARPS)
//  NUM_THREADS  32  threads per warp, active-mask width
//  ADDR_WIDTH   32  pc width
// PORTS  (IDX_W = $clog2(NUM_ENTRIES))
//  clk           in   1            clock
//  rst           in   1            sync active-high reset
//  launch_valid  in   1            allocate entry for a new warp
//  launch_ready  out  1            free entry available for launch this cycle
//  launch_pc     in   ADDR_WIDTH   warp start pc
//  launch_mask   in   NUM_THREADS  initial active mask
//  launch_wid    in   WID_W        warp id
//  sel_valid     out  1            selected entry presented to fetch
//  sel_ready     in   1            fetch accepts selection
//  sel_pc        out  ADDR_WIDTH   pc of selected entry
//  sel_mask      out  NUM_THREADS  mask of selected entry
//  sel_wid       out  WID_W        warp id of selected entry
//  sel_num       out  IDX_W        split_table_num of selected entry
//  upd_valid     in   1            pc update for an in-flight entry
//  upd_stall     in   1            1: entry goes STALLED; 0: READY
//  upd_pc        in   ADDR_WIDTH   next pc
//  upd_num       in   IDX_W        target entry
//  split_valid   in   1            divergence on entry split_src
//  split_ready   out  1            free entry available for split
//  split_src     in   IDX_W        diverging (in-flight) entry
//  split_mask    in   NUM_THREADS  taken-thread mask (subset of src mask)
//  split_pc      in   ADDR_WIDTH   taken target pc
//  split_nt_pc   in   ADDR_WIDTH   not-taken (fallthrough) pc
//  split_num     out  IDX_W        entry allocated by the split (valid with split_valid&ready)
//  wb_valid      in   1            retire entry wb_num (path exited/reconverged)
//  wb_num        in   IDX_W        entry to free
//  wake_valid    in   1            STALLED -> READY for entry wake_num
//  wake_num      in   IDX_W        entry to wake
//  free_count    out  IDX_W+1      number of FREE entries
// BEHAVIOUR
//  - Per-entry state: FREE, READY, INFLIGHT, STALLED. Reset: all FREE, pc/mask/wid=0;
//    sel_valid=0, sel_* = 0, launch_ready=split_ready=1, free_count=NUM_ENTRIES, split_num=0.
//  - Free-entry pick: lowest-index FREE entry (priority encoder), computed from registered state.
//  - Launch: launch_valid&launch_ready -> entry = READY{launch_pc,launch_mask,launch_wid} next edge.
//  - Split: split_valid&split_ready, src must be INFLIGHT: src <- READY{split_nt_pc,
//    src_mask & ~split_mask}; new <- READY{split_pc, split_mask, src wid}; split_num=new index
//    combinationally. split_mask == src_mask or 0 -> no alloc; src <- READY at taken/nt pc resp.
//  - Split priority over launch for the free entry: launch_ready = free_count>=1 and not
//    (split_valid & free_count==1). split_ready = free_count>=1.
//  - Select: round-robin over READY entries, pointer starts 0, advances to sel_num+1 on
//    handshake. sel_* combinational from registered state; sel_valid=|READY. On sel_valid&
//    sel_ready entry -> INFLIGHT next edge. Zero-cycle latency select, one-cycle state update.
//  - Update: upd_valid on INFLIGHT entry -> pc=upd_pc, state=upd_stall?STALLED:READY.
//  - Wake: STALLED -> READY; ignored in any other state. wb: any non-FREE -> FREE, mask=0.
//  - Same-entry conflicts, priority: wb > split (src) > update > wake > select. Select of
//    an entry that is also wb'd same cycle: handshake completes, entry ends FREE.
//  - Illegal ops (update/split on non-INFLIGHT, wb on FREE) are no-ops; SVA flags them.
//  - free_count registered, updated each edge: +wb frees - launch/split allocs.
//  - rst mid-operation: all in-flight state discarded next edge, regardless of other inputs.
// STRUCTURE
//  - gelato_types: split_table_num_t, split_state_e {FREE,READY,INFLIGHT,STALLED},
//    split_entry_t {state,pc,mask,wid}; NUM_ENTRIES/NUM_THREADS defaults.
//  - Sub-module gelato_rr_arbiter (N requests, grant index, advance-on-accept); reused for
//    free pick with rotation disabled (fixed priority).
//  - Existing select/update split-table interfaces carry sel_*/upd_* unchanged in width.
// TESTING
//  - Reset, launch pc=0x100 mask=0xFFFF_FFFF wid=3 -> sel_valid=1, sel_pc=0x100, sel_num=0.
//  - Launch 3 warps, sel_ready=1 forever -> sel_num 0,1,2, then sel_valid=0 (all INFLIGHT).
//  - Split entry0 mask 0x0000_FFFF pc 0x200 nt 0x104 -> split_num=1; entry0 mask 0xFFFF_0000
//    pc 0x104, entry1 mask 0x0000_FFFF pc 0x200, free_count=NUM_ENTRIES-2.
//  - Fill all 16 entries -> launch_ready=split_ready=0; same-cycle wb entry5 + launch held
//    -> launch accepted next cycle into entry5.
//  - free_count==1, split and launch same cycle -> split wins, launch stalls, count=0.
//  - upd_stall=1 on entry2 -> never selected until wake_num=2; wb+update same entry -> FREE.

Source files
------------

// File: rtl/gelato_split_table_pool_pkg.sv
// Shared types and default dimensions for the SIMT split-table pool.
package gelato_split_table_pool_pkg;

    localparam int NUM_ENTRIES_DEF = 16;
    localparam int NUM_WARPS_DEF   = 8;
    localparam int NUM_THREADS_DEF = 32;
    localparam int ADDR_WIDTH_DEF  = 32;
    localparam int IDX_W_DEF       = $clog2(NUM_ENTRIES_DEF);
    localparam int WID_W_DEF       = $clog2(NUM_WARPS_DEF);

    typedef logic [IDX_W_DEF-1:0] split_table_num_t;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_READY    = 2'd1,
        ST_INFLIGHT = 2'd2,
        ST_STALLED  = 2'd3
    } split_state_e;

    typedef struct packed {
        split_state_e               state;
        logic [ADDR_WIDTH_DEF-1:0]  pc;
        logic [NUM_THREADS_DEF-1:0] mask;
        logic [WID_W_DEF-1:0]       wid;
    } split_entry_t;

endpackage

// File: rtl/gelato_split_table_pool_rr_arbiter.sv
// N-way arbiter returning a grant index; with ROTATE=0 the pointer stays at 0 (fixed priority).
module gelato_split_table_pool_rr_arbiter #(
    parameter int N      = 16,
    parameter bit ROTATE = 1'b1,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic             valid,
    output logic [IDX_W-1:0] grant
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (ROTATE && accept) begin
            ptr_q <= grant + 1'b1;
        end
    end

    // Scan downward so the request closest to the pointer is the last (winning) assignment.
    always_comb begin
        valid = |req;
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr_q + IDX_W'(i);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/gelato_split_table_pool.sv
// Pool of SIMT split entries: launch allocation, divergence split, retire and round-robin select.
//   state       | meaning
//   ST_FREE     | entry unallocated, available for launch or split
//   ST_READY    | holds a pc waiting to be selected toward fetch
//   ST_INFLIGHT | selected, waiting for pc update / split / retire
//   ST_STALLED  | updated with stall, waiting for wake
module gelato_split_table_pool
    import gelato_split_table_pool_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int NUM_WARPS   = NUM_WARPS_DEF,
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    localparam int IDX_W      = $clog2(NUM_ENTRIES),
    localparam int WID_W      = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   launch_valid,
    output logic                   launch_ready,
    input  logic [ADDR_WIDTH-1:0]  launch_pc,
    input  logic [NUM_THREADS-1:0] launch_mask,
    input  logic [WID_W-1:0]       launch_wid,
    output logic                   sel_valid,
    input  logic                   sel_ready,
    output logic [ADDR_WIDTH-1:0]  sel_pc,
    output logic [NUM_THREADS-1:0] sel_mask,
    output logic [WID_W-1:0]       sel_wid,
    output logic [IDX_W-1:0]       sel_num,
    input  logic                   upd_valid,
    input  logic                   upd_stall,
    input  logic [ADDR_WIDTH-1:0]  upd_pc,
    input  logic [IDX_W-1:0]       upd_num,
    input  logic                   split_valid,
    output logic                   split_ready,
    input  logic [IDX_W-1:0]       split_src,
    input  logic [NUM_THREADS-1:0] split_mask,
    input  logic [ADDR_WIDTH-1:0]  split_pc,
    input  logic [ADDR_WIDTH-1:0]  split_nt_pc,
    output logic [IDX_W-1:0]       split_num,
    input  logic                   wb_valid,
    input  logic [IDX_W-1:0]       wb_num,
    input  logic                   wake_valid,
    input  logic [IDX_W-1:0]       wake_num,
    output logic [IDX_W:0]         free_count
);

    split_state_e           state_q [NUM_ENTRIES];
    split_state_e           state_d [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]  pc_q    [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]  pc_d    [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] mask_q  [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] mask_d  [NUM_ENTRIES];
    logic [WID_W-1:0]       wid_q   [NUM_ENTRIES];
    logic [WID_W-1:0]       wid_d   [NUM_ENTRIES];
    logic [IDX_W:0]         free_count_q, free_count_d;

    logic [NUM_ENTRIES-1:0] free_vec, free2_vec, ready_vec;
    logic [IDX_W-1:0]       free_idx, free2_idx, launch_idx;
    logic                   free_any, free2_any;
    logic [NUM_THREADS-1:0] src_mask;
    logic                   wb_free, split_fire, split_alloc, split_none, split_all;
    logic                   launch_fire, sel_fire;

    gelato_split_table_pool_rr_arbiter #(.N(NUM_ENTRIES), .ROTATE(1'b0)) u_free_pick (
        .clk(clk), .rst(rst), .req(free_vec), .accept(1'b0), .valid(free_any), .grant(free_idx)
    );

    // Second free entry lets a launch and an allocating split both land in one cycle.
    gelato_split_table_pool_rr_arbiter #(.N(NUM_ENTRIES), .ROTATE(1'b0)) u_free2_pick (
        .clk(clk), .rst(rst), .req(free2_vec), .accept(1'b0), .valid(free2_any), .grant(free2_idx)
    );

    gelato_split_table_pool_rr_arbiter #(.N(NUM_ENTRIES), .ROTATE(1'b1)) u_sel_arb (
        .clk(clk), .rst(rst), .req(ready_vec), .accept(sel_fire), .valid(sel_valid), .grant(sel_num)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
                wid_q[i]   <= '0;
            end
            free_count_q <= (IDX_W+1)'(NUM_ENTRIES);
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mask_q       <= mask_d;
            wid_q        <= wid_d;
            free_count_q <= free_count_d;
        end
    end

    always_comb begin
        src_mask    = mask_q[split_src];
        wb_free     = wb_valid && (state_q[wb_num] != ST_FREE);
        split_fire  = split_valid && split_ready && (state_q[split_src] == ST_INFLIGHT)
                      && !(wb_valid && (wb_num == split_src));
        split_none  = (split_mask == '0);
        split_all   = (split_mask == src_mask);
        split_alloc = split_fire && !split_none && !split_all;
        launch_fire = launch_valid && launch_ready;
        launch_idx  = split_alloc ? free2_idx : free_idx;
        sel_fire    = sel_valid && sel_ready;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            mask_d[i]  = mask_q[i];
            wid_d[i]   = wid_q[i];
            if (wb_valid && (wb_num == IDX_W'(i)) && (state_q[i] != ST_FREE)) begin
                state_d[i] = ST_FREE;
                mask_d[i]  = '0;
            end else if (split_fire && (split_src == IDX_W'(i))) begin
                state_d[i] = ST_READY;
                if (split_none) begin
                    pc_d[i] = split_nt_pc;
                end else if (split_all) begin
                    pc_d[i] = split_pc;
                end else begin
                    pc_d[i]   = split_nt_pc;
                    mask_d[i] = src_mask & ~split_mask;
                end
            end else if (split_alloc && (free_idx == IDX_W'(i))) begin
                state_d[i] = ST_READY;
                pc_d[i]    = split_pc;
                mask_d[i]  = split_mask;
                wid_d[i]   = wid_q[split_src];
            end else if (launch_fire && (launch_idx == IDX_W'(i))) begin
                state_d[i] = ST_READY;
                pc_d[i]    = launch_pc;
                mask_d[i]  = launch_mask;
                wid_d[i]   = launch_wid;
            end else if (upd_valid && (upd_num == IDX_W'(i)) && (state_q[i] == ST_INFLIGHT)) begin
                state_d[i] = upd_stall ? ST_STALLED : ST_READY;
                pc_d[i]    = upd_pc;
            end else if (wake_valid && (wake_num == IDX_W'(i)) && (state_q[i] == ST_STALLED)) begin
                state_d[i] = ST_READY;
            end else if (sel_fire && (sel_num == IDX_W'(i))) begin
                state_d[i] = ST_INFLIGHT;
            end
        end
        free_count_d = free_count_q + (IDX_W+1)'(wb_free)
                       - (IDX_W+1)'(launch_fire) - (IDX_W+1)'(split_alloc);
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_vec[i]  = (state_q[i] == ST_FREE);
            ready_vec[i] = (state_q[i] == ST_READY);
        end
        split_ready  = (free_count_q != '0);
        launch_ready = (free_count_q != '0)
                       && !(split_valid && (free_count_q == (IDX_W+1)'(1)));
        split_num    = free_idx;
        free_count   = free_count_q;
        sel_pc       = pc_q[sel_num];
        sel_mask     = mask_q[sel_num];
        sel_wid      = wid_q[sel_num];
    end

    always_comb begin
        free2_vec           = free_vec;
        free2_vec[free_idx] = 1'b0;
    end

    a_upd_inflight:   assert property (@(posedge clk) disable iff (rst)
                          upd_valid |-> state_q[upd_num] == ST_INFLIGHT);
    a_split_inflight: assert property (@(posedge clk) disable iff (rst)
                          split_valid |-> state_q[split_src] == ST_INFLIGHT);
    a_wb_allocated:   assert property (@(posedge clk) disable iff (rst)
                          wb_valid |-> state_q[wb_num] != ST_FREE);
    a_count_match:    assert property (@(posedge clk) disable iff (rst)
                          free_any == (free_count_q != '0));
    a_two_allocs:     assert property (@(posedge clk) disable iff (rst)
                          (launch_fire && split_alloc) |-> free2_any);

endmodule

// File: tb/tb_gelato_split_table_pool.sv
// Scoreboarded bench for the split-table pool: selections are predicted and popped on handshake.
module tb_gelato_split_table_pool;

    localparam int NE = 16;
    localparam int NW = 8;
    localparam int NT = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          launch_valid, launch_ready;
    logic [AW-1:0] launch_pc;
    logic [NT-1:0] launch_mask;
    logic [WW-1:0] launch_wid;
    logic          sel_valid, sel_ready;
    logic [AW-1:0] sel_pc;
    logic [NT-1:0] sel_mask;
    logic [WW-1:0] sel_wid;
    logic [IW-1:0] sel_num;
    logic          upd_valid, upd_stall;
    logic [AW-1:0] upd_pc;
    logic [IW-1:0] upd_num;
    logic          split_valid, split_ready;
    logic [IW-1:0] split_src;
    logic [NT-1:0] split_mask;
    logic [AW-1:0] split_pc, split_nt_pc;
    logic [IW-1:0] split_num;
    logic          wb_valid;
    logic [IW-1:0] wb_num;
    logic          wake_valid;
    logic [IW-1:0] wake_num;
    logic [IW:0]   free_count;

    gelato_split_table_pool #(.NUM_ENTRIES(NE), .NUM_WARPS(NW), .NUM_THREADS(NT), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_pc(launch_pc),
        .launch_mask(launch_mask), .launch_wid(launch_wid),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_pc(sel_pc), .sel_mask(sel_mask),
        .sel_wid(sel_wid), .sel_num(sel_num),
        .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc), .upd_num(upd_num),
        .split_valid(split_valid), .split_ready(split_ready), .split_src(split_src),
        .split_mask(split_mask), .split_pc(split_pc), .split_nt_pc(split_nt_pc), .split_num(split_num),
        .wb_valid(wb_valid), .wb_num(wb_num), .wake_valid(wake_valid), .wake_num(wake_num),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [NT-1:0] mask;
        logic [WW-1:0] wid;
        logic [IW-1:0] num;
    } sel_exp_t;

    sel_exp_t exp_q[$];
    sel_exp_t mon_e;
    int       n_cmp = 0;
    int       n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_sel(input logic [AW-1:0] pc, input logic [NT-1:0] mask,
                            input logic [WW-1:0] wid, input logic [IW-1:0] num);
        sel_exp_t e;
        e.pc = pc; e.mask = mask; e.wid = wid; e.num = num;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && sel_valid && sel_ready) begin
            if (exp_q.size() == 0) begin
                check("sel_sb_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("sel_pc",   64'(sel_pc),   64'(mon_e.pc));
                check("sel_mask", 64'(sel_mask), 64'(mon_e.mask));
                check("sel_wid",  64'(sel_wid),  64'(mon_e.wid));
                check("sel_num",  64'(sel_num),  64'(mon_e.num));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d scoreboard entries pending", exp_q.size());
        $fatal(1);
    end

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        launch_valid = 1'b0;
        upd_valid    = 1'b0;
        split_valid  = 1'b0;
        wb_valid     = 1'b0;
        wake_valid   = 1'b0;
    endtask

    task automatic launch_one(input logic [AW-1:0] pc, input logic [NT-1:0] mask, input logic [WW-1:0] wid);
        launch_valid = 1'b1; launch_pc = pc; launch_mask = mask; launch_wid = wid;
        settle();
        check("launch_ready", 64'(launch_ready), 64'd1);
        adv();
        launch_valid = 1'b0;
    endtask

    task automatic run_sel(input int bound);
        bit done;
        done = 1'b0;
        sel_ready = 1'b1;
        for (int i = 0; i < bound && !done; i++) begin
            settle();
            if (!sel_valid) done = 1'b1;
            else adv();
        end
        check("sel_idle", 64'(sel_valid), 64'd0);
        check("sel_sb_empty", 64'(exp_q.size()), 64'd0);
        adv();
        sel_ready = 1'b0;
    endtask

    initial begin
        int  k;
        bit  acc;
        rst = 1'b1; sel_ready = 1'b0; idle();
        launch_pc = '0; launch_mask = '0; launch_wid = '0;
        upd_stall = 1'b0; upd_pc = '0; upd_num = '0;
        split_src = '0; split_mask = '0; split_pc = '0; split_nt_pc = '0;
        wb_num = '0; wake_num = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        settle();
        check("rst_sel_valid",   64'(sel_valid),    64'd0);
        check("rst_sel_pc",      64'(sel_pc),       64'd0);
        check("rst_sel_num",     64'(sel_num),      64'd0);
        check("rst_launch_rdy",  64'(launch_ready), 64'd1);
        check("rst_split_rdy",   64'(split_ready),  64'd1);
        check("rst_free_count",  64'(free_count),   64'd16);
        check("rst_split_num",   64'(split_num),    64'd0);
        adv();

        // first launch: zero-cycle select view
        launch_one(32'h100, 32'hFFFF_FFFF, 3'd3);
        settle();
        check("l0_sel_valid", 64'(sel_valid),  64'd1);
        check("l0_sel_pc",    64'(sel_pc),     64'h100);
        check("l0_sel_num",   64'(sel_num),    64'd0);
        check("l0_sel_wid",   64'(sel_wid),    64'd3);
        check("l0_free",      64'(free_count), 64'd15);
        adv();
        push_sel(32'h100, 32'hFFFF_FFFF, 3'd3, 4'd0);
        run_sel(4);

        // divergence split of entry 0
        split_valid = 1'b1; split_src = 4'd0; split_mask = 32'h0000_FFFF;
        split_pc = 32'h200; split_nt_pc = 32'h104;
        settle();
        check("sp_ready", 64'(split_ready), 64'd1);
        check("sp_num",   64'(split_num),   64'd1);
        adv(); idle();
        settle();
        check("sp_free",     64'(free_count), 64'd14);
        check("sp_sel_num",  64'(sel_num),    64'd1);
        adv();
        push_sel(32'h200, 32'h0000_FFFF, 3'd3, 4'd1);
        push_sel(32'h104, 32'hFFFF_0000, 3'd3, 4'd0);
        run_sel(6);

        // three launches, round-robin select
        launch_one(32'h300, 32'hF0F0_F0F0, 3'd1);
        launch_one(32'h400, 32'h0000_00FF, 3'd2);
        launch_one(32'h500, 32'h1234_5678, 3'd5);
        settle();
        check("rr_free", 64'(free_count), 64'd11);
        adv();
        push_sel(32'h300, 32'hF0F0_F0F0, 3'd1, 4'd2);
        push_sel(32'h400, 32'h0000_00FF, 3'd2, 4'd3);
        push_sel(32'h500, 32'h1234_5678, 3'd5, 4'd4);
        run_sel(8);

        // stall entry 2, ready-update entry 3
        upd_valid = 1'b1; upd_num = 4'd2; upd_stall = 1'b1; upd_pc = 32'h340;
        adv();
        upd_num = 4'd3; upd_stall = 1'b0; upd_pc = 32'h440;
        adv(); idle();
        settle();
        check("upd_sel_num", 64'(sel_num), 64'd3);
        check("upd_sel_pc",  64'(sel_pc),  64'h440);
        adv();
        push_sel(32'h440, 32'h0000_00FF, 3'd2, 4'd3);
        run_sel(6);
        sel_ready = 1'b1;
        repeat (3) begin
            settle();
            check("stalled_hidden", 64'(sel_valid), 64'd0);
            adv();
        end
        sel_ready = 1'b0;
        wake_valid = 1'b1; wake_num = 4'd2;
        adv(); idle();
        settle();
        check("wake_sel_num", 64'(sel_num), 64'd2);
        check("wake_sel_pc",  64'(sel_pc),  64'h340);
        adv();
        push_sel(32'h340, 32'hF0F0_F0F0, 3'd1, 4'd2);
        run_sel(6);
        wake_valid = 1'b1; wake_num = 4'd4;
        adv(); idle();
        settle();
        check("wake_ignored", 64'(sel_valid), 64'd0);
        adv();

        // retire and update on the same entry: retire wins
        wb_valid = 1'b1; wb_num = 4'd2;
        upd_valid = 1'b1; upd_num = 4'd2; upd_stall = 1'b0; upd_pc = 32'h350;
        adv(); idle();
        settle();
        check("wbupd_free",  64'(free_count), 64'd12);
        check("wbupd_sel",   64'(sel_valid),  64'd0);
        adv();

        // fill the pool
        k = 0;
        for (int t = 0; t < 24 && k < 12; t++) begin
            launch_valid = 1'b1;
            launch_pc    = 32'(32'h1000 + k * 16);
            launch_mask  = 32'(32'h0101_0000 + k);
            launch_wid   = 3'(k % 8);
            settle();
            acc = launch_ready;
            adv();
            if (acc) k++;
        end
        launch_valid = 1'b0;
        check("fill_launches", 64'(k), 64'd12);
        settle();
        check("full_launch_rdy", 64'(launch_ready), 64'd0);
        check("full_split_rdy",  64'(split_ready),  64'd0);
        check("full_free",       64'(free_count),   64'd0);
        adv();
        wb_valid = 1'b1; wb_num = 4'd5;
        launch_valid = 1'b1; launch_pc = 32'h900; launch_mask = 32'hA5A5_A5A5; launch_wid = 3'd6;
        settle();
        check("full_wb_blocked", 64'(launch_ready), 64'd0);
        adv();
        wb_valid = 1'b0;
        settle();
        check("refill_rdy",  64'(launch_ready), 64'd1);
        check("refill_free", 64'(free_count),   64'd1);
        adv();
        launch_valid = 1'b0;
        settle();
        check("refill_full", 64'(free_count), 64'd0);
        adv();
        push_sel(32'h900, 32'hA5A5_A5A5, 3'd6, 4'd5);
        for (int e = 6; e < 16; e++) begin
            push_sel(32'(32'h1000 + (e - 4) * 16), 32'(32'h0101_0000 + (e - 4)), 3'((e - 4) % 8), 4'(e));
        end
        push_sel(32'h1000, 32'h0101_0000, 3'd0, 4'd2);
        run_sel(20);

        // last free entry: split beats launch
        wb_valid = 1'b1; wb_num = 4'd7;
        adv(); idle();
        split_valid = 1'b1; split_src = 4'd0; split_mask = 32'hFF00_0000;
        split_pc = 32'h600; split_nt_pc = 32'h108;
        launch_valid = 1'b1; launch_pc = 32'hBAD; launch_mask = 32'h1; launch_wid = 3'd0;
        settle();
        check("prio_launch_rdy", 64'(launch_ready), 64'd0);
        check("prio_split_rdy",  64'(split_ready),  64'd1);
        check("prio_split_num",  64'(split_num),    64'd7);
        adv(); idle();
        settle();
        check("prio_free", 64'(free_count), 64'd0);
        adv();
        push_sel(32'h600, 32'hFF00_0000, 3'd3, 4'd7);
        push_sel(32'h108, 32'h00FF_0000, 3'd3, 4'd0);
        run_sel(6);

        // degenerate splits: all threads taken, then none taken
        wb_valid = 1'b1; wb_num = 4'd1;
        adv(); idle();
        split_valid = 1'b1; split_src = 4'd0; split_mask = 32'h00FF_0000;
        split_pc = 32'h700; split_nt_pc = 32'h7FC;
        adv(); idle();
        settle();
        check("dgen_all_free", 64'(free_count), 64'd1);
        adv();
        push_sel(32'h700, 32'h00FF_0000, 3'd3, 4'd0);
        run_sel(4);
        split_valid = 1'b1; split_src = 4'd0; split_mask = 32'h0;
        split_pc = 32'h7AA; split_nt_pc = 32'h710;
        adv(); idle();
        settle();
        check("dgen_none_free", 64'(free_count), 64'd1);
        adv();
        push_sel(32'h710, 32'h00FF_0000, 3'd3, 4'd0);
        run_sel(4);

        // reset in the middle of traffic
        launch_valid = 1'b1; launch_pc = 32'hC00; launch_mask = 32'h3; launch_wid = 3'd1;
        rst = 1'b1;
        adv();
        rst = 1'b0; idle();
        settle();
        check("mrst_free",      64'(free_count),   64'd16);
        check("mrst_sel_valid", 64'(sel_valid),    64'd0);
        check("mrst_launch",    64'(launch_ready), 64'd1);
        check("mrst_sel_pc",    64'(sel_pc),       64'd0);
        adv();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
